lvds_ser_tx: RTL
================

// Module: lvds_ser_tx
// PURPOSE
//  Framed serial transmitter that drives a complementary pair (O/OB) into a differential output buffer.
//  - Takes parallel words over a valid/ready handshake.
//  - Frames each word as: start bit 0, DATA_WIDTH data bits, stop bit 1.
//  - Idle line is 1 (O=1, OB=0).
//  - Pairs with the differential input-buffer receive path on the far end of the link.
//  - O and OB are never equal, so a latching differential receiver always sees a defined state.
// PARAMETERS
//  DATA_WIDTH    8  data bits per frame, legal 1..32
//  CLKS_PER_BIT  1  CLK cycles per serial bit, legal >=1
//  MSB_FIRST     0  0: DI[0] sent first; 1: DI[DATA_WIDTH-1] sent first
// PORTS
//  CLK       in   1           clock, all state on rising edge
//  RST       in   1           asynchronous reset, active-high
//  EN        in   1           1: transmit enabled; 0: finish current frame, start no new one
//  DI        in   DATA_WIDTH  parallel word to send
//  DI_VALID  in   1           DI holds a word
//  DI_READY  out  1           holding register free; word accepted when DI_VALID & DI_READY at CLK edge
//  O         out  1           serial data, true leg (registered)
//  OB        out  1           serial data, complement leg (registered, always ~O)
//  BUSY      out  1           state != IDLE or holding register full
// BEHAVIOUR
//  Reset (async, while RST=1)
//   - O=1, OB=0, BUSY=0.
//   - FSM=IDLE; holding register empty; counters cleared.
//  DI_READY
//   - Combinational: EN & ~hold_full.
//   - During reset it equals EN.
//  Storage: one-word holding register plus one shift register.
//   - Accept at edge k sets hold_full.
//  FSM states: IDLE, START, DATA, STOP.
//  Bit timing
//   - Baud counter counts 0..CLKS_PER_BIT-1.
//   - Each state/bit is held exactly CLKS_PER_BIT cycles.
//   - Bit index counts 0..DATA_WIDTH-1 in DATA.
//  Transitions
//   - IDLE->START: on edge where hold_full & EN.
//     - Holding register moves to shifter and hold_full clears.
//     - O=0 is visible after that edge.
//     - A word accepted at edge k from IDLE gives start bit after edge k+1.
//   - START->DATA: after CLKS_PER_BIT cycles; O = first data bit per MSB_FIRST.
//   - DATA->DATA: next bit every CLKS_PER_BIT cycles.
//   - DATA->STOP: after last data bit; O=1.
//   - STOP->START: at end of stop bit if hold_full & EN.
//     - No idle gap between frames.
//     - Holding register transfers to shifter on this edge.
//   - STOP->IDLE: at end of stop bit otherwise.
//  Frame timing
//   - Frame length = (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
//   - Sustained throughput = one word per frame.
//  EN=0
//   - DI_READY=0.
//   - Frame in progress completes unchanged.
//   - Held word is retained and does not start until EN=1.
//  Simultaneous events
//   - Accept on the same edge that the holding register empties into the shifter is not possible.
//     - DI_READY is low while hold_full.
//     - DI_READY rises the cycle after transfer.
//  DI
//   - Sampled only on the accept edge.
//   - Later DI changes do not affect the frame.
//  Reset mid-frame
//   - Frame aborts immediately.
//   - O=1/OB=0 asynchronously; held word discarded.
//   - After release, FSM is IDLE and O=1.
//  Invariant: OB == ~O at all times, including reset.
// TESTING
//  1. RST=1 at arbitrary points, EN=1 -> O=1, OB=0, BUSY=0, DI_READY=1 during and after reset.
//  2. Defaults, send 8'hA5 -> O = 0,1,0,1,0,0,1,0,1,1 on 10 consecutive cycles, then 1.
//     DI_READY high again 1 cycle after accept.
//  3. Back-to-back 8'h00 then 8'hFF, DI_VALID held -> 20 cycles with no idle between the stop and start bits.
//     O = 0,0x8,1,0,1x8,1; BUSY high throughout.
//  4. CLKS_PER_BIT=4, MSB_FIRST=1, send 8'h80 -> start 4 cycles 0, then 4 cycles 1, then 28 cycles 0, then stop 4 cycles 1.
//     Frame totals 40 cycles.
//  5. RST pulsed during data bit 3 with a second word held -> O=1/OB=0 without waiting for CLK.
//     After release: IDLE, hold empty, no frame sent.
//  6. EN dropped mid-frame with word held -> frame completes, then line idles, DI_READY=0.
//     EN=1 -> held word starts on the next edge.
//  All tests: assert OB==~O every cycle.

Source files
------------

// File: rtl/lvds_ser_tx_if.sv
// Parallel-word handshake into the serial transmitter: enable, data word,
// valid from the producer and ready back from the transmitter.
interface lvds_ser_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic [DATA_WIDTH-1:0] di;
  logic                  di_valid;
  logic                  di_ready;

  modport master (
    output en,
    output di,
    output di_valid,
    input  di_ready
  );

  modport slave (
    input  en,
    input  di,
    input  di_valid,
    output di_ready
  );
endinterface

// File: rtl/lvds_ser_tx.sv
// Framed serial transmitter driving a complementary pair (O/OB).
// Frame: start bit 0, DATA_WIDTH data bits, stop bit 1; idle line is 1.
// One holding register feeds one shift register so frames run back to back.
module lvds_ser_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic            clk,
  input  logic            rst,
  lvds_ser_tx_if.slave    bus,
  output logic            o_o,
  output logic            ob_o,
  output logic            busy_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  o_q, o_d;
  logic                  ob_q;

  logic                  accept;
  logic                  start_next;
  logic                  baud_last;
  logic [DATA_WIDTH-1:0] shift_adv;

  // Bit that goes on the line first out of a given shifter image.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
  endfunction

  // Ready only depends on enable and holding-register occupancy, so it
  // tracks EN even while reset is asserted.
  assign bus.di_ready = bus.en & ~hold_full_q;
  assign accept       = bus.en & ~hold_full_q & bus.di_valid;
  assign start_next   = hold_full_q & bus.en;
  assign baud_last    = (baud_q == BAUD_LAST);

  assign o_o    = o_q;
  assign ob_o   = ob_q;
  assign busy_o = (state_q != S_IDLE) | hold_full_q;

  // Next-state, datapath and line-level decode for the framing FSM.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    o_d         = o_q;
    shift_adv   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

    // Accept and transfer are mutually exclusive: accept needs an empty
    // holding register, transfer needs a full one.
    if (accept) begin
      hold_d      = bus.di;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        o_d = 1'b1;
        if (start_next) begin
          state_d     = S_START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          baud_d      = '0;
          o_d         = 1'b0;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          o_d     = first_bit(shift_q);
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            o_d     = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_ONE;
            shift_d = shift_adv;
            o_d     = first_bit(shift_adv);
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (start_next) begin
            // Chain straight into the next start bit, no idle gap.
            state_d     = S_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            o_d         = 1'b0;
          end else begin
            state_d = S_IDLE;
            o_d     = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        o_d     = 1'b1;
      end
    endcase
  end

  // State and line registers; reset forces the idle line level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      o_q         <= 1'b1;
      ob_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      o_q         <= o_d;
      ob_q        <= ~o_d;
    end
  end

endmodule
